// File: rtl/aes_en_iter_core_if.sv
// Handshake and data bundle for aes_en_iter_core.
// Signal names keep their direction suffix as seen from the core.
//   slave  : the AES core (consumes plaintext and round keys, produces ciphertext)
//   master : the environment (plaintext source, key expansion, ciphertext sink)
// Signals:
//   abort_i             synchronous abort of the current block
//   pt_valid_i/ready_o  plaintext handshake, pt_data_i 128-bit plaintext
//   key_req_o/sel_o     round key request and index 0..NR, key_vld_i/round_key_i reply
//   ct_valid_o/ready_i  ciphertext handshake, ct_data_o 128-bit ciphertext
//   busy_o              core not idle
interface aes_en_iter_core_if;
  logic         abort_i;
  logic         pt_valid_i;
  logic         pt_ready_o;
  logic [127:0] pt_data_i;
  logic         key_req_o;
  logic [3:0]   key_sel_o;
  logic         key_vld_i;
  logic [127:0] round_key_i;
  logic         ct_valid_o;
  logic         ct_ready_i;
  logic [127:0] ct_data_o;
  logic         busy_o;

  modport master (
    output abort_i, pt_valid_i, pt_data_i, key_vld_i, round_key_i, ct_ready_i,
    input  pt_ready_o, key_req_o, key_sel_o, ct_valid_o, ct_data_o, busy_o
  );

  modport slave (
    input  abort_i, pt_valid_i, pt_data_i, key_vld_i, round_key_i, ct_ready_i,
    output pt_ready_o, key_req_o, key_sel_o, ct_valid_o, ct_data_o, busy_o
  );
endinterface

// File: rtl/aes_en_iter_core.sv
// Iterative AES encryption core: one round per accepted round key, NR = 10/12/14.
// Byte s[r][c] of any 128-bit word sits at data[127-8*(4c+r) -: 8].
// Ports:
//   aes_clk  clock
//   resetn   asynchronous active-low reset
//   aes_io   aes_en_iter_core_if.slave: plaintext in, round key request/reply,
//            ciphertext out, abort, busy
// Build option AES_EN_SUBREG_EN: registers SubBytes in a separate SUB cycle before each
// key cycle of rounds 1..NR (zero-stall latency 2*NR+1 instead of NR+1).
module aes_en_iter_core #(
  parameter int unsigned NR = 10
) (
  input logic                aes_clk,
  input logic                resetn,
  aes_en_iter_core_if.slave  aes_io
);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_nr_check
    $fatal(1, "aes_en_iter_core: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] LastRnd = 4'(NR);

  // StSub is only entered when the SubBytes register is built in.
  typedef enum logic [1:0] {StIdle, StRound, StSub, StDone} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] st_q, st_d;
  logic [3:0]   rnd_q, rnd_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // Round datapath, everything except AddRoundKey.
  logic [127:0] sb, rin, sr, mc, pre_key;

  always_comb begin
    sb = sub_bytes(st_q);
`ifdef AES_EN_SUBREG_EN
    rin = st_q;  // already substituted by the preceding SUB cycle
`else
    rin = sb;
`endif
    sr = shift_rows(rin);
    mc = mix_columns(sr);
    if (rnd_q == 4'd0) begin
      pre_key = st_q;
    end else if (rnd_q == LastRnd) begin
      pre_key = sr;
    end else begin
      pre_key = mc;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    st_d  = st_q;
    rnd_d = rnd_q;
    case (fsm_q)
      StIdle: begin
        if (aes_io.pt_valid_i) begin
          st_d  = aes_io.pt_data_i;
          rnd_d = 4'd0;
          fsm_d = StRound;
        end
      end
      StRound: begin
        if (aes_io.key_vld_i) begin
          st_d = pre_key ^ aes_io.round_key_i;
          if (rnd_q == LastRnd) begin
            fsm_d = StDone;
          end else begin
            rnd_d = rnd_q + 4'd1;
`ifdef AES_EN_SUBREG_EN
            fsm_d = StSub;
`endif
          end
        end
      end
      StSub: begin
        st_d  = sb;
        fsm_d = StRound;
      end
      StDone: begin
        if (aes_io.ct_ready_i) begin
          fsm_d = StIdle;
          rnd_d = 4'd0;
        end
      end
      default: fsm_d = StIdle;
    endcase
    // Abort overrides everything, including a plaintext offered in the same cycle.
    if (aes_io.abort_i) begin
      fsm_d = StIdle;
      st_d  = '0;
      rnd_d = 4'd0;
    end
  end

  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      fsm_q <= StIdle;
      st_q  <= '0;
      rnd_q <= 4'd0;
    end else begin
      fsm_q <= fsm_d;
      st_q  <= st_d;
      rnd_q <= rnd_d;
    end
  end

  always_comb begin
    aes_io.pt_ready_o = (fsm_q == StIdle);
    aes_io.key_req_o  = (fsm_q == StRound);
    aes_io.key_sel_o  = rnd_q;
    aes_io.ct_valid_o = (fsm_q == StDone);
    aes_io.ct_data_o  = (fsm_q == StDone) ? st_q : '0;
    aes_io.busy_o     = (fsm_q != StIdle);
  end

endmodule

// File: tb/tb_aes_en_iter_core.sv
module tb_aes_en_iter_core;
  localparam int NR = 10;
`ifdef AES_EN_SUBREG_EN
  localparam int BaseLat = 2 * NR + 1;
`else
  localparam int BaseLat = NR + 1;
`endif

  logic aes_clk;
  logic resetn;
  aes_en_iter_core_if bus ();

  aes_en_iter_core #(.NR(NR)) dut (
    .aes_clk (aes_clk),
    .resetn  (resetn),
    .aes_io  (bus)
  );

  initial aes_clk = 1'b0;
  always #5 aes_clk = ~aes_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  byte unsigned sbox_t [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [127:0] rk [15];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // FIPS-197 key schedule; key is left-aligned in 256 bits.
  function automatic void expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rk[0][127-8*k -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) s[k] = sbox_t[s[k]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*c+w] = s[4*((c+w)%4)+w];
      if (r != nr) begin
        for (int c = 0; c < 4; c++)
          for (int w = 0; w < 4; w++)
            s[4*c+w] = xt(t[4*c+w]) ^ xt(t[4*c+(w+1)%4]) ^ t[4*c+(w+1)%4] ^
                       t[4*c+(w+2)%4] ^ t[4*c+(w+3)%4];
      end else begin
        s = t;
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk[r][127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  function automatic logic [255:0] seq_key(input int nr);
    logic [255:0] k;
    k = '0;
    for (int i = 0; i < 4 * (nr - 6); i++) k[255-8*i -: 8] = 8'(i);
    return k;
  endfunction

  function automatic logic [127:0] seq_ct(input int nr);
    case (nr)
      12:      return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      14:      return 128'h8ea2b7ca516745bfeafc49904b496089;
      default: return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    endcase
  endfunction

  localparam logic [127:0] SeqPt = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FipsPt = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] FipsKey = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] FipsCt = 128'h3925841d02dc09fbdc118597196a0b32;

  // Key source: answers key_req_o with the requested round key; random valid in mode 1.
  int key_mode = 0;
  initial begin
    bus.key_vld_i   = 1'b0;
    bus.round_key_i = '0;
    forever begin
      @(posedge aes_clk);
      #1;
      bus.key_vld_i   = (key_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.round_key_i = bus.key_req_o ? rk[bus.key_sel_o]
                                      : {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // Transaction-level model: one block in flight, keys consumed so far, expected ciphertext.
  bit           inflight = 0;
  int           exp_rnd = 0;
  int           stall_cnt = 0;
  logic [127:0] exp_ct = '0;

  always @(negedge aes_clk) begin
    if (!resetn) begin
      inflight = 0;
      exp_rnd  = 0;
      chk("rst_ctl", {bus.pt_ready_o, bus.key_req_o, bus.ct_valid_o, bus.busy_o,
                      bus.key_sel_o}, 8'h80);
      chk("rst_ct_data", bus.ct_data_o, '0);
    end else begin
      chk("pt_ready", bus.pt_ready_o, !inflight);
      chk("busy", bus.busy_o, inflight);
      chk("ct_valid", bus.ct_valid_o, inflight && exp_rnd == NR + 1);
`ifdef AES_EN_SUBREG_EN
      chk("key_req", bus.key_req_o & !(inflight && exp_rnd <= NR), 0);
`else
      chk("key_req", bus.key_req_o, inflight && exp_rnd <= NR);
`endif
      if (bus.key_req_o) chk("key_sel", bus.key_sel_o, exp_rnd);
      if (bus.ct_valid_o && inflight) chk("ct_data", bus.ct_data_o, exp_ct);
      if (bus.key_req_o && !bus.key_vld_i) stall_cnt++;
      if (bus.abort_i) begin
        inflight = 0;
      end else if (!inflight) begin
        if (bus.pt_valid_i) begin
          exp_ct   = encrypt(bus.pt_data_i, NR);
          inflight = 1;
          exp_rnd  = 0;
        end
      end else if (exp_rnd <= NR) begin
        if (bus.key_req_o && bus.key_vld_i) exp_rnd++;
      end else if (bus.ct_ready_i) begin
        inflight = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge aes_clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] pt);
    bus.pt_valid_i = 1'b1;
    bus.pt_data_i  = pt;
    step(1);
    bus.pt_valid_i = 1'b0;
    stall_cnt      = 0;
  endtask

  task automatic run_block(input string tag, input logic [127:0] pt,
                           input logic [127:0] exp, input int hold);
    int cyc;
    accept(pt);
    cyc = 0;
    while (!bus.ct_valid_o && cyc < 300) begin
      step(1);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, BaseLat + stall_cnt);
    chk({tag, "_ct"}, bus.ct_data_o, exp);
    for (int i = 0; i < hold; i++) begin
      bus.pt_valid_i = 1'b1;
      bus.pt_data_i  = ~pt;
      step(1);
      chk({tag, "_hold_valid"}, bus.ct_valid_o, 1);
      chk({tag, "_hold_ready"}, bus.pt_ready_o, 0);
      chk({tag, "_hold_ct"}, bus.ct_data_o, exp);
    end
    bus.pt_valid_i = 1'b0;
    bus.ct_ready_i = 1'b1;
    step(1);
    bus.ct_ready_i = 1'b0;
    chk({tag, "_ct_valid_fall"}, bus.ct_valid_o, 0);
    chk({tag, "_pt_ready_rise"}, bus.pt_ready_o, 1);
  endtask

  task automatic wait_sel(input string tag, input int sel);
    int n;
    n = 0;
    while (!(bus.key_req_o && bus.key_sel_o == 4'(sel)) && n < 100) begin
      step(1);
      n++;
    end
    chk({tag, "_reached"}, {bus.key_req_o, bus.key_sel_o}, {1'b1, 4'(sel)});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt_b, ct_b;
    logic [255:0] key_b;
    resetn         = 1'b0;
    bus.abort_i    = 1'b0;
    bus.pt_valid_i = 1'b0;
    bus.pt_data_i  = '0;
    bus.ct_ready_i = 1'b0;
    step(2);
    chk("reset_pt_ready", bus.pt_ready_o, 1);
    chk("reset_idle", {bus.key_req_o, bus.ct_valid_o, bus.busy_o, bus.key_sel_o}, 0);
    chk("reset_ct_data", bus.ct_data_o, '0);

    // Pin the model to published answers.
    expand(seq_key(10), 4, 10);
    chk("model_aes128", encrypt(SeqPt, 10), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    expand(seq_key(12), 6, 12);
    chk("model_aes192", encrypt(SeqPt, 12), 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    expand(seq_key(14), 8, 14);
    chk("model_aes256", encrypt(SeqPt, 14), 128'h8ea2b7ca516745bfeafc49904b496089);
    expand(FipsKey, 4, 10);
    chk("model_fips_b", encrypt(FipsPt, 10), FipsCt);

    if (NR == 10) begin
      pt_b = FipsPt; key_b = FipsKey; ct_b = FipsCt;
    end else begin
      pt_b = SeqPt; key_b = seq_key(NR); ct_b = seq_ct(NR);
    end

    @(negedge aes_clk);
    #1 resetn = 1'b1;
    step(1);

    // Keys always valid: exact latency and key_sel_o 0..NR.
    expand(seq_key(NR), NR - 6, NR);
    key_mode = 0;
    run_block("seq", SeqPt, seq_ct(NR), 0);

    // Random key stalls, then a held ciphertext with a second plaintext offered.
    expand(key_b, NR - 6, NR);
    key_mode = 1;
    run_block("stall", pt_b, ct_b, 0);
    run_block("hold", pt_b, ct_b, 5);
    key_mode = 0;

    // Abort wins over plaintext offered in IDLE.
    bus.abort_i    = 1'b1;
    bus.pt_valid_i = 1'b1;
    bus.pt_data_i  = pt_b;
    step(1);
    bus.abort_i    = 1'b0;
    bus.pt_valid_i = 1'b0;
    chk("idle_abort_no_accept", {bus.pt_ready_o, bus.busy_o}, 2'b10);

    // Abort at round 4.
    accept(pt_b);
    wait_sel("abort", 4);
    bus.abort_i = 1'b1;
    step(1);
    bus.abort_i = 1'b0;
    chk("abort_ctl", {bus.pt_ready_o, bus.key_req_o, bus.ct_valid_o, bus.busy_o}, 4'b1000);
    chk("abort_ct_data", bus.ct_data_o, '0);

    // Reset in the middle of round 6 of a new block.
    accept(SeqPt);
    wait_sel("rst", 6);
    resetn = 1'b0;
    #1;
    chk("midrst_ctl", {bus.pt_ready_o, bus.key_req_o, bus.ct_valid_o, bus.busy_o,
                       bus.key_sel_o}, 8'h80);
    chk("midrst_ct_data", bus.ct_data_o, '0);
    @(negedge aes_clk);
    #1 resetn = 1'b1;
    step(1);

    run_block("recover", pt_b, ct_b, 0);
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
